// File: rtl/bin_search_ctrl.sv
// Binary-search controller: drives the A operand of an external magnitude comparator.
// It narrows an inclusive [lo, hi] range using the GT/LT/EQ flags until the target is found or the range is exhausted.
module bin_search_ctrl #(
    parameter int unsigned N  = 32,
    parameter int unsigned CW = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [N-1:0]  bound_lo,
    input  logic [N-1:0]  bound_hi,
    output logic [N-1:0]  probe,
    input  logic          GT,
    input  logic          LT,
    input  logic          EQ,
    output logic          busy,
    output logic          done,
    output logic          found,
    output logic          err,
    output logic [N-1:0]  result,
    output logic [CW-1:0] iters
);

    typedef enum logic [1:0] {StIdle, StCalc, StCmp, StDone} state_e;

    state_e        r_state, w_state_nxt;
    logic [N-1:0]  r_lo, w_lo_nxt;
    logic [N-1:0]  r_hi, w_hi_nxt;
    logic [N-1:0]  r_probe, w_probe_nxt;
    logic [N-1:0]  r_result, w_result_nxt;
    logic [CW-1:0] r_iters, w_iters_nxt;
    logic          r_found, w_found_nxt;
    logic          r_err, w_err_nxt;

    logic [N-1:0]  w_span;
    logic          w_flags_legal;

    assign w_span        = r_hi - r_lo;
    assign w_flags_legal = ({GT, LT, EQ} == 3'b100) || ({GT, LT, EQ} == 3'b010) ||
                           ({GT, LT, EQ} == 3'b001);

    always_comb begin
        w_state_nxt  = r_state;
        w_lo_nxt     = r_lo;
        w_hi_nxt     = r_hi;
        w_probe_nxt  = r_probe;
        w_result_nxt = r_result;
        w_iters_nxt  = r_iters;
        w_found_nxt  = r_found;
        w_err_nxt    = r_err;
        case (r_state)
            StIdle: begin
                if (start) begin
                    w_lo_nxt     = bound_lo;
                    w_hi_nxt     = bound_hi;
                    w_found_nxt  = 1'b0;
                    w_err_nxt    = 1'b0;
                    w_result_nxt = '0;
                    w_iters_nxt  = '0;
                    w_state_nxt  = StCalc;
                end
            end
            StCalc: begin
                // lo > hi can only happen with reversed bounds at entry
                if (r_lo > r_hi) begin
                    w_state_nxt = StDone;
                end else begin
                    w_probe_nxt = r_lo + (w_span >> 1);
                    w_state_nxt = StCmp;
                end
            end
            StCmp: begin
                w_iters_nxt = r_iters + CW'(1);
                w_state_nxt = StDone;
                if (!w_flags_legal) begin
                    w_err_nxt   = 1'b1;
                    w_found_nxt = 1'b0;
                end else if (EQ) begin
                    w_found_nxt  = 1'b1;
                    w_result_nxt = r_probe;
                end else if (GT) begin
                    // Edge guards keep probe-1 / probe+1 from wrapping
                    if (r_probe != r_lo) begin
                        w_hi_nxt    = r_probe - N'(1);
                        w_state_nxt = StCalc;
                    end
                end else begin
                    if (r_probe != r_hi) begin
                        w_lo_nxt    = r_probe + N'(1);
                        w_state_nxt = StCalc;
                    end
                end
            end
            StDone: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_lo     <= '0;
            r_hi     <= '0;
            r_probe  <= '0;
            r_result <= '0;
            r_iters  <= '0;
            r_found  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_lo     <= w_lo_nxt;
            r_hi     <= w_hi_nxt;
            r_probe  <= w_probe_nxt;
            r_result <= w_result_nxt;
            r_iters  <= w_iters_nxt;
            r_found  <= w_found_nxt;
            r_err    <= w_err_nxt;
        end
    end

    assign probe  = r_probe;
    assign result = r_result;
    assign iters  = r_iters;
    assign found  = r_found;
    assign err    = r_err;
    assign busy   = (r_state == StCalc) || (r_state == StCmp);
    assign done   = (r_state == StDone);

endmodule

// File: tb/tb_bin_search_ctrl.sv
// Bench for bin_search_ctrl (N=8): vector table with expected probe sequences and results.
// Results are scoreboarded through a queue; reset and ignored-start cases are covered too.
module tb_bin_search_ctrl;

    localparam int unsigned N  = 8;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [N-1:0]  bound_lo = '0;
    logic [N-1:0]  bound_hi = '0;
    logic [N-1:0]  probe;
    logic          GT, LT, EQ;
    logic          busy, done, found, err;
    logic [N-1:0]  result;
    logic [CW-1:0] iters;

    logic [N-1:0]  target = '0;
    bit            bad = 1'b0;

    always #5 clk = ~clk;

    // Behavioural comparator; 'bad' forces the illegal GT=LT=1 combination
    always_comb begin
        GT = bad | (probe > target);
        LT = bad | (probe < target);
        EQ = !bad && (probe == target);
    end

    bin_search_ctrl #(.N(N), .CW(CW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bound_lo (bound_lo),
        .bound_hi (bound_hi),
        .probe    (probe),
        .GT       (GT),
        .LT       (LT),
        .EQ       (EQ),
        .busy     (busy),
        .done     (done),
        .found    (found),
        .err      (err),
        .result   (result),
        .iters    (iters)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0]  lo;
        logic [7:0]  hi;
        logic [7:0]  t;
        bit          bad;
        int          np;
        logic [71:0] probes;    // first probe in the top byte
        bit          found;
        logic [7:0]  result;
        int          iters;
        int          done_cyc;
        bit          err;
        int          extra_start; // cycle in which a stray start is driven (0 = none)
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    function automatic vec_t mk(input logic [7:0] lo, input logic [7:0] hi, input logic [7:0] t,
                                input bit b, input int np, input logic [71:0] pr, input bit f,
                                input logic [7:0] r, input int it, input int dc, input bit e,
                                input int xs);
        vec_t v;
        v.lo = lo; v.hi = hi; v.t = t; v.bad = b; v.np = np; v.probes = pr;
        v.found = f; v.result = r; v.iters = it; v.done_cyc = dc; v.err = e;
        v.extra_start = xs;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        int k;
        int np;
        bit seen;
        logic [7:0] got [9];
        vec_t e;
        @(negedge clk);
        bound_lo = v.lo;
        bound_hi = v.hi;
        target   = v.t;
        bad      = v.bad;
        start    = 1'b1;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        bound_lo = 8'hAA;
        bound_hi = 8'h55;
        k = 1; np = 0; seen = 1'b0;
        while (!seen && k <= 40) begin
            start = (k == v.extra_start);
            if (busy && (k % 2 == 0) && np < 9) begin
                got[np] = probe;
                np++;
            end
            if (done) seen = 1'b1;
            else begin
                @(posedge clk);
                #1;
                k++;
            end
        end
        if (!seen) begin
            start = 1'b0;
            checks++;
            failures++;
            $display("FAIL vec%0d timeout: got no done expected done in cycle %0d", idx, v.done_cyc);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            return;
        end
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL vec%0d scoreboard: got done expected empty queue", idx);
            return;
        end
        e = exp_q.pop_front();
        chk($sformatf("vec%0d done_cycle", idx), k, e.done_cyc);
        chk($sformatf("vec%0d found", idx), found, e.found);
        chk($sformatf("vec%0d result", idx), result, e.result);
        chk($sformatf("vec%0d iters", idx), iters, e.iters);
        chk($sformatf("vec%0d err", idx), err, e.err);
        chk($sformatf("vec%0d busy_in_done", idx), busy, 0);
        chk($sformatf("vec%0d probe_count", idx), np, e.np);
        for (int i = 0; i < np && i < e.np; i++)
            chk($sformatf("vec%0d probe%0d", idx, i), got[i], e.probes[71-8*i -: 8]);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk($sformatf("vec%0d done_pulse_end", idx), done, 0);
        chk($sformatf("vec%0d idle_after_done", idx), busy, 0);
        chk($sformatf("vec%0d result_held", idx), result, e.result);
    endtask

    initial begin
        vecs.push_back(mk(8'd0, 8'd255, 8'd100, 0, 8,
            {8'd127, 8'd63, 8'd95, 8'd111, 8'd103, 8'd99, 8'd101, 8'd100, 8'd0},
            1, 8'd100, 8, 17, 0, 0));
        vecs.push_back(mk(8'd0, 8'd255, 8'd255, 0, 9,
            {8'd127, 8'd191, 8'd223, 8'd239, 8'd247, 8'd251, 8'd253, 8'd254, 8'd255},
            1, 8'd255, 9, 19, 0, 0));
        vecs.push_back(mk(8'd0, 8'd255, 8'd0, 0, 8,
            {8'd127, 8'd63, 8'd31, 8'd15, 8'd7, 8'd3, 8'd1, 8'd0, 8'd0},
            1, 8'd0, 8, 17, 0, 0));
        vecs.push_back(mk(8'd10, 8'd20, 8'd50, 0, 4,
            {8'd15, 8'd18, 8'd19, 8'd20, 40'd0}, 0, 8'd0, 4, 9, 0, 0));
        vecs.push_back(mk(8'd30, 8'd20, 8'd25, 0, 0, 72'd0, 0, 8'd0, 0, 2, 0, 0));
        vecs.push_back(mk(8'd0, 8'd255, 8'd100, 1, 1, {8'd127, 64'd0}, 0, 8'd0, 1, 3, 1, 0));
        vecs.push_back(mk(8'd10, 8'd20, 8'd5, 0, 3,
            {8'd15, 8'd12, 8'd10, 48'd0}, 0, 8'd0, 3, 7, 0, 0));
        // Stray start while busy, then stray start in DONE
        vecs.push_back(mk(8'd0, 8'd255, 8'd100, 0, 8,
            {8'd127, 8'd63, 8'd95, 8'd111, 8'd103, 8'd99, 8'd101, 8'd100, 8'd0},
            1, 8'd100, 8, 17, 0, 5));
        vecs.push_back(mk(8'd10, 8'd20, 8'd50, 0, 4,
            {8'd15, 8'd18, 8'd19, 8'd20, 40'd0}, 0, 8'd0, 4, 9, 0, 9));

        #2;
        chk("reset probe", probe, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset found", found, 0);
        chk("reset err", err, 0);
        chk("reset result", result, 0);
        chk("reset iters", iters, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

        // Reset in IDLE clears held results
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("idle_rst result", result, 0);
        chk("idle_rst found", found, 0);
        chk("idle_rst iters", iters, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset during the second CMP of a search
        @(negedge clk);
        bound_lo = 8'd0;
        bound_hi = 8'd255;
        target   = 8'd100;
        bad      = 1'b0;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("midrst pre busy", busy, 1);
        chk("midrst pre probe", probe, 63);
        chk("midrst pre iters", iters, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst probe", probe, 0);
        chk("midrst busy", busy, 0);
        chk("midrst done", done, 0);
        chk("midrst iters", iters, 0);
        chk("midrst found", found, 0);
        chk("midrst err", err, 0);
        chk("midrst result", result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("post_rst idle busy", busy, 0);
            chk("post_rst idle done", done, 0);
        end
        run_vec(vecs[3], 99);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bin_search_ctrl.md
# bin_search_ctrl

Sequential binary-search controller that drives the A operand of an external N-bit magnitude comparator and consumes its GT/LT/EQ flags. It locates an unknown value (on the comparator's B side) within a programmable inclusive range `[bound_lo, bound_hi]`, using at most N+1 probes. It is the consumer end of the comparator interface: the comparator produces GT/LT/EQ, and this block generates the probes and interprets the results.

## Interface
- `N`, default 32: operand width of `probe`, bounds and `result`.
- `CW`, default 6: width of `iters`; it must hold N+1.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `start`  in  1  sampled only in IDLE; begins a search.
- `bound_lo`  in  N  inclusive lower bound, latched on start.
- `bound_hi`  in  N  inclusive upper bound, latched on start.
- `probe`  out  N  registered value driven to the comparator A input.
- `GT`, `LT`, `EQ`  in  1 each  comparator flags for probe vs target.
- `busy`  out  1  high in CALC and CMP.
- `done`  out  1  one-cycle pulse at the end of a search.
- `found`  out  1  target located; valid from `done` until the next start.
- `err`  out  1  illegal comparator flags seen; valid from `done` until the next start.
- `result`  out  N  located value if found, else 0; held until the next start.
- `iters`  out  CW  number of CMP cycles in the last search.

## Operation
States are IDLE, CALC, CMP and DONE.

- **IDLE:** on `start`=1:
  - latch `lo`=`bound_lo`, `hi`=`bound_hi`
  - clear `found`, `err`, `result` and `iters`
  - go to CALC
- **CALC:**
  - If `lo`>`hi` (empty range, only possible at entry), go to DONE with `found`=0.
  - Otherwise set `probe` = lo + ((hi - lo) >> 1). This is computed in N bits and cannot overflow.
  - Go to CMP.
- **CMP:** `probe` is stable. Sample the flags at the closing edge and increment `iters`.
  - Exactly one flag high is legal. Any other combination (none, or two or more) sets `err`=1, `found`=0, and goes to DONE.
  - EQ: `found`=1, `result`=`probe`, go to DONE.
  - GT (probe > target):
    - if `probe`==`lo`, not found; go to DONE
    - else `hi`=`probe`-1, go to CALC
  - LT (probe < target):
    - if `probe`==`hi`, not found; go to DONE
    - else `lo`=`probe`+1, go to CALC
  - The `probe`==`lo` / `probe`==`hi` guards prevent underflow at 0 and overflow at 2^N-1. No wider arithmetic is needed.
- **DONE:** `done`=1 for this one cycle, then go to IDLE.
- `start` is ignored outside IDLE, including in DONE.
- Reset asserted in any state: immediately return to IDLE. `probe`, `result`, `iters`, `busy`, `done`, `found` and `err` all go to 0.

## Timing
- Call the edge that samples `start` E0. Cycle k is the cycle after edge E(k-1).
- A search with p probes:
  - CALC occupies cycles 1, 3, …, 2p-1.
  - CMP occupies cycles 2, 4, …, 2p.
  - DONE occupies cycle 2p+1.
- An empty range gives CALC in cycle 1 and DONE in cycle 2, with `iters`=0.
- `probe` changes only at the edge leaving CALC. It is constant for the whole CMP cycle, so the combinational comparator settles within that cycle.
- Over the full range [0, 2^N-1], p ≤ N+1. Worst-case latency is 2N+3 cycles from E0 to the end of DONE.
- `busy` is low in DONE. A new `start` is accepted in the cycle after DONE at the earliest.
- `found`, `err`, `result` and `iters` are final when `done` is high and stay stable until the next accepted start.

## Test plan
All scenarios use N=8 and a behavioural comparator against a target T.

1. Bounds 0..255, T=100:
   - probes 127, 63, 95, 111, 103, 99, 101, 100
   - `done` in cycle 17; `found`=1, `result`=100, `iters`=8
2. Bounds 0..255, T=255:
   - probes 127, 191, 223, 239, 247, 251, 253, 254, 255
   - `iters`=9 (N+1); `done` in cycle 19; no overflow
3. Bounds 0..255, T=0:
   - probes 127, 63, 31, 15, 7, 3, 1, 0
   - `found`=1, `result`=0, `iters`=8; no underflow
4. Bounds 10..20, T=50:
   - probes 15, 18, 19, 20 (all LT)
   - `found`=0, `result`=0, `iters`=4, `done` in cycle 9
5. Bounds 30..20:
   - `done` in cycle 2, `found`=0, `iters`=0
   - Separately, force GT=LT=1 in the first CMP: `err`=1, `found`=0, `iters`=1, `done` in cycle 3.
6. Reset and start handling:
   - Assert `rst_n`=0 mid-search (during a CMP). All outputs go to 0 immediately and the block is in IDLE.
   - Pulse `start` while `busy` is high. It has no effect, and the running search completes unchanged.
